// File: rtl/channel_threshold.sv
// Three-stage RGB888 channel/luma band classifier that emits a per-pixel mask with delay-matched pixel data.
// Define THRESH_COUNT_EN to build the per-frame masked-pixel counter (otherwise its outputs are tied to 0).
module channel_threshold #(
  parameter int unsigned COUNT_W = 21
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  input  logic [1:0]         channel_sel_in,
  input  logic [7:0]         lower_in,
  input  logic [7:0]         upper_in,
  input  logic               valid_in,
  input  logic [23:0]        pixel_in,
  output logic               valid_out,
  output logic [23:0]        pixel_out,
  output logic [7:0]         channel_out,
  output logic               mask_out,
  output logic               frame_start_out,
  output logic [COUNT_W-1:0] mask_count_out,
  output logic               count_valid_out
);

  typedef enum logic [1:0] {CH_R = 2'b00, CH_G = 2'b01, CH_B = 2'b10, CH_Y = 2'b11} chan_e;

  chan_e       sel_sh_q, sel_d, sel1_q;
  logic [7:0]  lo_sh_q, up_sh_q, lo_d, up_d;
  logic [23:0] pix1_q, pix2_q, pix3_q;
  logic        v1_q, v2_q, v3_q;
  logic        fs1_q, fs2_q, fs3_q;
  logic [7:0]  lo1_q, up1_q, lo2_q, up2_q;
  logic [15:0] pr_d, pg_d, pb_d, pr1_q, pg1_q, pb1_q, ysum;
  logic [7:0]  ch2_d, ch2_q, ch3_q;
  logic        m3_d, m3_q;

  // Config on a frame_start cycle comes straight from the inputs, so the first pixel already uses it.
  always_comb begin
    sel_d = frame_start_in ? chan_e'(channel_sel_in) : sel_sh_q;
    lo_d  = frame_start_in ? lower_in : lo_sh_q;
    up_d  = frame_start_in ? upper_in : up_sh_q;
    pr_d  = 16'(pixel_in[23:16]) * 16'd77;
    pg_d  = 16'(pixel_in[15:8])  * 16'd150;
    pb_d  = 16'(pixel_in[7:0])   * 16'd29;
  end

  always_comb begin
    ysum  = pr1_q + pg1_q + pb1_q;
    ch2_d = '0;
    unique case (sel1_q)
      CH_R: ch2_d = pix1_q[23:16];
      CH_G: ch2_d = pix1_q[15:8];
      CH_B: ch2_d = pix1_q[7:0];
      CH_Y: ch2_d = ysum[15:8];
    endcase
  end

  always_comb begin
    if (lo2_q <= up2_q) m3_d = (ch2_q >= lo2_q) && (ch2_q <= up2_q);
    else                m3_d = (ch2_q >= lo2_q) || (ch2_q <= up2_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_sh_q <= CH_R;
      lo_sh_q  <= 8'h80;
      up_sh_q  <= 8'hFF;
      pix1_q <= '0; v1_q <= 1'b0; fs1_q <= 1'b0; sel1_q <= CH_R;
      lo1_q  <= '0; up1_q <= '0; pr1_q <= '0; pg1_q <= '0; pb1_q <= '0;
      pix2_q <= '0; v2_q <= 1'b0; fs2_q <= 1'b0; lo2_q <= '0; up2_q <= '0; ch2_q <= '0;
      pix3_q <= '0; v3_q <= 1'b0; fs3_q <= 1'b0; ch3_q <= '0; m3_q <= 1'b0;
    end else begin
      if (frame_start_in) begin
        sel_sh_q <= sel_d;
        lo_sh_q  <= lo_d;
        up_sh_q  <= up_d;
      end
      pix1_q <= pixel_in; v1_q <= valid_in; fs1_q <= frame_start_in; sel1_q <= sel_d;
      lo1_q  <= lo_d; up1_q <= up_d; pr1_q <= pr_d; pg1_q <= pg_d; pb1_q <= pb_d;
      pix2_q <= pix1_q; v2_q <= v1_q; fs2_q <= fs1_q; lo2_q <= lo1_q; up2_q <= up1_q;
      ch2_q  <= ch2_d;
      pix3_q <= pix2_q; v3_q <= v2_q; fs3_q <= fs2_q;
      ch3_q  <= v2_q ? ch2_q : '0;
      m3_q   <= v2_q && m3_d;
    end
  end

  assign valid_out       = v3_q;
  assign pixel_out       = pix3_q;
  assign channel_out     = ch3_q;
  assign mask_out        = m3_q;
  assign frame_start_out = fs3_q;

`ifdef THRESH_COUNT_EN
  logic [COUNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic               cv_q, cv_d, seen_q, seen_d, hit;

  // Stage-2 values are used so the report lands on the same cycle as frame_start_out.
  always_comb begin
    hit    = v2_q && m3_d;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    cv_d   = 1'b0;
    seen_d = seen_q;
    if (fs2_q) begin
      cnt_d  = seen_q ? acc_q : '0;
      cv_d   = 1'b1;
      seen_d = 1'b1;
      acc_d  = hit ? COUNT_W'(1) : '0;
    end else if (hit && (acc_q != '1)) begin
      acc_d = acc_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      cv_q   <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      cv_q   <= cv_d;
      seen_q <= seen_d;
    end
  end

  assign mask_count_out  = cnt_q;
  assign count_valid_out = cv_q;
`else
  assign mask_count_out  = '0;
  assign count_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_channel_threshold.sv
// Self-checking bench for channel_threshold: behavioural model compared every cycle plus literal anchors.
module tb_channel_threshold;
  localparam int unsigned COUNT_W = 21;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               frame_start_in = 1'b0;
  logic [1:0]         channel_sel_in = '0;
  logic [7:0]         lower_in = '0;
  logic [7:0]         upper_in = '0;
  logic               valid_in = 1'b0;
  logic [23:0]        pixel_in = '0;
  logic               valid_out;
  logic [23:0]        pixel_out;
  logic [7:0]         channel_out;
  logic               mask_out;
  logic               frame_start_out;
  logic [COUNT_W-1:0] mask_count_out;
  logic               count_valid_out;

  channel_threshold #(.COUNT_W(COUNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .channel_sel_in(channel_sel_in), .lower_in(lower_in), .upper_in(upper_in),
    .valid_in(valid_in), .pixel_in(pixel_in), .valid_out(valid_out),
    .pixel_out(pixel_out), .channel_out(channel_out), .mask_out(mask_out),
    .frame_start_out(frame_start_out), .mask_count_out(mask_count_out),
    .count_valid_out(count_valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        v;
    logic [23:0] px;
    logic [7:0]  ch;
    logic        m;
    logic        fs;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        v;
    logic [7:0]  ch;
    logic        m;
    logic        fs;
    logic [23:0] px;
  } lit_t;

  typedef struct {
    int                 cyc;
    logic [COUNT_W-1:0] cnt;
  } clit_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  logic  chk_en = 1'b0;
  lit_t  litq[$];
  clit_t clitq[$];

  exp_t               pipe[3];
  logic [1:0]         sh_sel = 2'b00;
  logic [7:0]         sh_lo = 8'h80;
  logic [7:0]         sh_up = 8'hFF;
  logic [COUNT_W-1:0] m_acc = '0;
  logic [COUNT_W-1:0] m_mc = '0;
  logic               m_cv = 1'b0;
  logic               m_seen = 1'b0;

  function automatic exp_t mk(logic v, logic fs, logic [1:0] sel, logic [7:0] lo,
                              logic [7:0] up, logic [23:0] px);
    exp_t e;
    int r, g, b, c;
    logic m;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    case (sel)
      2'd0: c = r;
      2'd1: c = g;
      2'd2: c = b;
      default: c = (77 * r + 150 * g + 29 * b) / 256;
    endcase
    if (lo <= up) m = (c >= int'(lo)) && (c <= int'(up));
    else          m = (c >= int'(lo)) || (c <= int'(up));
    e.v  = v;
    e.px = px;
    e.fs = fs;
    e.ch = v ? 8'(c) : 8'h00;
    e.m  = v && m;
    return e;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model: three-slot delay of spec-derived results, plus output-side frame counter.
  always @(posedge clk_in or posedge rst_in) begin : model
    exp_t nw, oe;
    logic hit;
    if (rst_in) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '{1'b0, 24'h0, 8'h0, 1'b0, 1'b0};
      sh_sel <= 2'b00; sh_lo <= 8'h80; sh_up <= 8'hFF;
      m_acc <= '0; m_mc <= '0; m_cv <= 1'b0; m_seen <= 1'b0;
    end else begin
      if (frame_start_in)
        nw = mk(valid_in, 1'b1, channel_sel_in, lower_in, upper_in, pixel_in);
      else
        nw = mk(valid_in, 1'b0, sh_sel, sh_lo, sh_up, pixel_in);
      if (frame_start_in) begin
        sh_sel <= channel_sel_in; sh_lo <= lower_in; sh_up <= upper_in;
      end
      oe  = pipe[1];
      hit = oe.v && oe.m;
      if (oe.fs) begin
        m_mc   <= m_seen ? m_acc : '0;
        m_cv   <= 1'b1;
        m_seen <= 1'b1;
        m_acc  <= hit ? COUNT_W'(1) : '0;
      end else begin
        m_cv <= 1'b0;
        if (hit && m_acc != {COUNT_W{1'b1}}) m_acc <= m_acc + COUNT_W'(1);
      end
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= nw;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("valid", 32'(valid_out), 32'(pipe[2].v));
      check("pixel", 32'(pixel_out), 32'(pipe[2].px));
      check("channel", 32'(channel_out), 32'(pipe[2].ch));
      check("mask", 32'(mask_out), 32'(pipe[2].m));
      check("fs", 32'(frame_start_out), 32'(pipe[2].fs));
`ifdef THRESH_COUNT_EN
      check("count", 32'(mask_count_out), 32'(m_mc));
      check("count_valid", 32'(count_valid_out), 32'(m_cv));
`else
      check("count_off", 32'(mask_count_out), 32'h0);
      check("count_valid_off", 32'(count_valid_out), 32'h0);
`endif
      if (litq.size() > 0 && litq[0].cyc == cyc) begin
        check("lit_valid", 32'(valid_out), 32'(litq[0].v));
        check("lit_channel", 32'(channel_out), 32'(litq[0].ch));
        check("lit_mask", 32'(mask_out), 32'(litq[0].m));
        check("lit_fs", 32'(frame_start_out), 32'(litq[0].fs));
        check("lit_pixel", 32'(pixel_out), 32'(litq[0].px));
        void'(litq.pop_front());
      end
      if (clitq.size() > 0 && clitq[0].cyc == cyc) begin
`ifdef THRESH_COUNT_EN
        check("lit_count", 32'(mask_count_out), 32'(clitq[0].cnt));
        check("lit_count_valid", 32'(count_valid_out), 32'h1);
`else
        check("lit_count_off", 32'(mask_count_out), 32'h0);
        check("lit_count_valid_off", 32'(count_valid_out), 32'h0);
`endif
        void'(clitq.pop_front());
      end
    end
  end

  // Expectation for the pixel driven in the current slot, visible three cycles later.
  task automatic lit(input logic v, input logic [7:0] ch, input logic m, input logic fs,
                     input logic [23:0] px);
    litq.push_back('{cyc + 3, v, ch, m, fs, px});
  endtask

  task automatic clit(input logic [COUNT_W-1:0] c);
    clitq.push_back('{cyc + 3, c});
  endtask

  task automatic drv(input logic fs, input logic v, input logic [1:0] sel,
                     input logic [7:0] lo, input logic [7:0] up, input logic [23:0] px);
    frame_start_in = fs; valid_in = v; channel_sel_in = sel;
    lower_in = lo; upper_in = up; pixel_in = px;
    @(negedge clk_in);
  endtask

  // Mid-frame slot with junk config on the inputs: the shadow registers must ignore it.
  task automatic mid(input logic v, input logic [23:0] px);
    drv(1'b0, v, 2'b11, 8'h5A, 8'h3C, px);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mid(1'b0, 24'hA5A5A5);
  endtask

  initial begin
    @(negedge clk_in);
    chk_en = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;

    lit(1, 8'hFF, 1, 1, 24'hFF0000); drv(1, 1, 2'b00, 8'h80, 8'hFF, 24'hFF0000);

    lit(1, 8'h80, 1, 1, 24'h808080); drv(1, 1, 2'b11, 8'h40, 8'hC0, 24'h808080);
    lit(1, 8'hFF, 0, 0, 24'hFFFFFF); mid(1, 24'hFFFFFF);
    lit(1, 8'h00, 0, 0, 24'h000000); mid(1, 24'h000000);

    drv(1, 1, 2'b01, 8'h00, 8'h10, 24'h000000);
    lit(1, 8'hF0, 0, 0, 24'h00F000); drv(0, 1, 2'b01, 8'h00, 8'hFF, 24'h00F000);
    lit(1, 8'hF0, 1, 1, 24'h00F000); drv(1, 1, 2'b01, 8'h00, 8'hFF, 24'h00F000);

    lit(1, 8'h20, 1, 1, 24'h000020); drv(1, 1, 2'b10, 8'hC0, 8'h40, 24'h000020);
    lit(1, 8'h80, 0, 0, 24'h000080); mid(1, 24'h000080);
    lit(1, 8'hC0, 1, 0, 24'h0000C0); mid(1, 24'h0000C0);
    lit(1, 8'h40, 1, 0, 24'h000040); mid(1, 24'h000040);

    lit(1, 8'h20, 1, 0, 24'h000020); mid(1, 24'h000020);
    lit(0, 8'h00, 0, 0, 24'h000020); mid(0, 24'h000020);
    lit(1, 8'h80, 0, 0, 24'h000080); mid(1, 24'h000080);
    lit(1, 8'hC0, 1, 0, 24'h0000C0); mid(1, 24'h0000C0);
    lit(0, 8'h00, 0, 0, 24'h0000FF); mid(0, 24'h0000FF);
    idle(3);

    // 10-pixel frame, R in band 80..FF for 90, A0, FF, 80 (7F is just below).
    drv(1, 1, 2'b00, 8'h80, 8'hFF, 24'h900000);
    mid(1, 24'h100000); mid(1, 24'hA00000); mid(1, 24'h200000); mid(1, 24'h300000);
    mid(0, 24'hFF0000);
    mid(1, 24'hFF0000); mid(1, 24'h000000); mid(1, 24'h800000); mid(1, 24'h7F0000);
    mid(1, 24'h400000);
    clit(4); drv(1, 1, 2'b00, 8'h80, 8'hFF, 24'h000000);
    mid(1, 24'h010000); mid(1, 24'h7F0000); mid(0, 24'hFF0000); mid(1, 24'h200000);
    clit(0); drv(1, 1, 2'b00, 8'h80, 8'hFF, 24'h000000);
    idle(4);

    mid(1, 24'h00FF00); mid(1, 24'hFF00FF); mid(1, 24'h123456);
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    lit(1, 8'hFF, 1, 0, 24'hFF0000); mid(1, 24'hFF0000);
    lit(1, 8'h7F, 0, 0, 24'h7F0000); mid(1, 24'h7F0000);
    idle(5);

    check("lit_drained", 32'(litq.size() + clitq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
